// File: rtl/alu_pkg.sv
// Shared definitions for the ALU bitwise-logic output stage: opcodes,
// per-bit gate function select, and the result entry layout carried by
// the MAIN/SKID registers.
package alu_pkg;

    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00110;

    localparam int ALU_DATA_W = 32;

    // Function applied by every per-bit gate cell; FN_NONE yields 0.
    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_XOR  = 2'b10,
        FN_NONE = 2'b11
    } gate_fn_e;

    // One buffered result beat; the stage packs its skid-buffer payload in
    // exactly this order {result, zero, err}.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
        logic                  err;
    } alu_entry_t;

    localparam int ALU_ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_gate_cell.sv
// Single-bit logic gate cell: one instance per result bit.
module alu_gate_cell
    import alu_pkg::*;
(
    input  logic     a,
    input  logic     b,
    input  gate_fn_e fn,
    output logic     y
);

    // Select the bitwise function; unsupported functions drive 0.
    always_comb begin
        y = 1'b0;
        case (fn)
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer (MAIN drives the outputs, SKID absorbs one beat of
// backpressure). in_ready and out_* come straight from flops, so there is
// no combinational path from out_ready to in_ready.
module alu_skid_buf #(
    parameter int W = 34
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         drn;

    assign acc = in_valid && in_ready;
    assign drn = main_valid && out_ready;

    // MAIN/SKID occupancy and data movement; order is MAIN first, then SKID.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // branch reads the pre-edge values of main/skid regardless of order.
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: data registers are cleared too because out_result must
            // read 0 straight out of reset, not just be qualified by valid.
            main_data  <= '0;
            skid_data  <= '0;
        end else if (!main_valid) begin
            if (acc) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end
        end else if (drn) begin
            if (skid_valid) begin
                // in_ready was low, so nothing can be accepted this cycle.
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (acc) begin
                main_data <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/alu_logic_stage.sv
// Registered output stage for the ALU bitwise-logic path: opcode decode,
// per-bit gate cells, zero/err flags, and a 2-entry skid buffer.
// Optional feature macro: ALU_LOGIC_XOR_EN enables opcode 00110 = XOR.
module alu_logic_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_err
);

    localparam int ENTRY_W = DATA_W + 2;

    gate_fn_e            fn;
    logic [DATA_W-1:0]   gate_y;
    logic                res_zero;
    logic                res_err;
    logic [ENTRY_W-1:0]  in_entry;
    logic [ENTRY_W-1:0]  out_entry;

    // Decode the opcode into a gate function; anything unknown is an error.
    always_comb begin
        fn = FN_NONE;
        case (in_opcode)
            OP_AND:  fn = FN_AND;
            OP_OR:   fn = FN_OR;
`ifdef ALU_LOGIC_XOR_EN
            OP_XOR:  fn = FN_XOR;
`endif
            default: fn = FN_NONE;
        endcase
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        alu_gate_cell u_cell (
            .a  (in_a[i]),
            .b  (in_b[i]),
            .fn (fn),
            .y  (gate_y[i])
        );
    end

    // FN_NONE already forces gate_y to 0, so zero is set on errors too.
    assign res_zero = ~|gate_y;
    assign res_err  = (fn == FN_NONE);
    assign in_entry = {gate_y, res_zero, res_err};

    alu_skid_buf #(
        .W (ENTRY_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_result = out_entry[ENTRY_W-1:2];
    assign out_zero   = out_entry[1];
    assign out_err    = out_entry[0];

endmodule

// File: tb/tb_alu_logic_stage.sv
// Self-checking bench for alu_logic_stage: directed scenarios followed by a
// randomized stream scored against a FIFO reference model.
module tb_alu_logic_stage;
    import alu_pkg::*;

    localparam int W = ALU_DATA_W;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_opcode;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_err;

    int n_cmp;
    int n_bad;

    alu_logic_stage #(.DATA_W(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: what the stage should emit for one accepted beat.
    function automatic alu_entry_t ref_model(input logic [4:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        alu_entry_t e;
        e.err = 1'b0;
        if (op == OP_AND)      e.result = a & b;
        else if (op == OP_OR)  e.result = a | b;
`ifdef ALU_LOGIC_XOR_EN
        else if (op == OP_XOR) e.result = a ^ b;
`endif
        else begin
            e.result = '0;
            e.err    = 1'b1;
        end
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = v;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, OP_OR, 32'hFFFF_FFFF, 32'h1234_5678);
        tick();
        tick();
        reset_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_result !== '0) begin n_bad++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        n_cmp++; if ({out_zero, out_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b%b exp=00", out_zero, out_err); end
        drive(1'b0, '0, '0, '0);
        tick();
    endtask

    // Send one beat with out_ready=1 and check it appears the next cycle.
    task automatic single_beat(input string name, input logic [4:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_res, input logic exp_zero,
                               input logic exp_err);
        out_ready = 1'b1;
        drive(1'b1, op, a, b);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready); end
        tick();
        drive(1'b0, '0, '0, '0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got=%b exp=1", name, out_valid); end
        n_cmp++; if (out_result !== exp_res) begin n_bad++; $display("FAIL %s_result got=%h exp=%h", name, out_result, exp_res); end
        n_cmp++; if ({out_zero, out_err} !== {exp_zero, exp_err}) begin
            n_bad++; $display("FAIL %s_flags got=zero%b,err%b exp=zero%b,err%b", name, out_zero, out_err, exp_zero, exp_err);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drained got=%b exp=0", name, out_valid); end
    endtask

    task automatic test_single();
        single_beat("single_and", OP_AND, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF000_000F, 1'b0, 1'b0);
    endtask

    task automatic test_zero_flag();
        single_beat("zero_or", OP_OR, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        single_beat("zero_and", OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, OP_OR, 32'h0000_0001, 32'h0000_0010);
        tick();
        drive(1'b1, OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_1st got=%b exp=1", in_ready); end
        tick();
        drive(1'b1, OP_OR, 32'hDEAD_0000, 32'h0000_BEEF);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_after_2nd got=%b exp=0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_held got=%b exp=0", in_ready); end
        n_cmp++; if (out_result !== 32'h0000_0011) begin n_bad++; $display("FAIL bp_main_held got=%h exp=00000011", out_result); end
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_drain got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h0F0F_0000) begin
            n_bad++; $display("FAIL bp_second_beat got=%b/%h exp=1/0f0f0000", out_valid, out_result);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_third_not_accepted got=%b exp=0", out_valid); end
    endtask

    task automatic test_bad_opcode();
        single_beat("bad_op", 5'b00100, 32'hFFFF_FFFF, 32'h1357_9BDF, 32'h0, 1'b1, 1'b1);
`ifdef ALU_LOGIC_XOR_EN
        single_beat("xor_op", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
`else
        single_beat("xor_off", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_random_stream();
        alu_entry_t q[$];
        alu_entry_t exp;
        logic [4:0] ops[4];
        int  accepted;
        int  cycles;
        bit  reset_done;
        bit  do_reset;
        logic acc;
        logic drn;
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR; ops[3] = 5'b00000;
        accepted   = 0;
        cycles     = 0;
        reset_done = 0;
        while (accepted < 10000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_opcode = (($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 2)]);
            in_a      = $urandom;
            in_b      = (($urandom_range(0, 5) == 0) ? ~in_a : $urandom);
            n_cmp++; if (out_valid !== (q.size() != 0)) begin
                n_bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b held=%0d", cycles, out_valid, q.size());
            end
            n_cmp++; if (in_ready !== (q.size() < 2)) begin
                n_bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b held=%0d", cycles, in_ready, q.size());
            end
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn && q.size() != 0) begin
                n_cmp++; if ({out_result, out_zero, out_err} !== q[0]) begin
                    n_bad++; $display("FAIL rnd_data cyc=%0d got=%h/z%b/e%b exp=%h/z%b/e%b",
                                      cycles, out_result, out_zero, out_err, q[0].result, q[0].zero, q[0].err);
                end
            end
            exp = ref_model(in_opcode, in_a, in_b);
            do_reset = (accepted == 5000) && !reset_done;
            if (do_reset) reset_n = 1'b0;
            tick();
            cycles++;
            if (do_reset) begin
                reset_n    = 1'b1;
                reset_done = 1;
                q.delete();
            end else begin
                if (drn && q.size() != 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back(exp);
                    accepted++;
                end
            end
        end
        n_cmp++; if (accepted < 10000) begin n_bad++; $display("FAIL rnd_budget accepted=%0d exp=10000", accepted); end
        // Drain what is still held and confirm nothing extra appears.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (out_valid === 1'b1) begin
                n_cmp++; if (q.size() == 0 || {out_result, out_zero, out_err} !== q[0]) begin
                    n_bad++; $display("FAIL rnd_drain got=%h held=%0d", out_result, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            tick();
        end
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rnd_final got_valid=%b left=%0d exp=0/0", out_valid, q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_zero_flag();
        test_backpressure();
        test_bad_opcode();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
